universal_shift_reg: RTL
========================

Name: universal_shift_reg

Overview:
Parametrised successor to the 4-bit serial-in/parallel-out shift register. It adds configurable width and runtime mode select: hold, serial shift (SIPO/SISO), parallel load (PISO/PIPO) and rotate. Shift direction is selectable and a frame-complete strobe flags when WIDTH serial bits have been assembled. It sits between bit-serial links and word-wide datapath logic in the digital-logic lab designs.

Parameters:
WIDTH, 4, register width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH), width of the internal serial-bit counter (derived, not overridden).

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
en  input  1  clock enable; 0 = hold all state
mode  input  2  00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE
dir  input  1  0 = shift/rotate right (toward bit 0), 1 = left (toward bit WIDTH-1)
si  input  1  serial data in
pi  input  WIDTH  parallel data in
so  output  1  serial data out
po  output  WIDTH  parallel data out (register contents)
frame_done  output  1  one-cycle strobe: WIDTH serial bits assembled

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Priority at each rising edge is rst, then en, then mode.
- Reset (rst=1 at an edge):
  - data register = 0 and bit counter = 0.
  - frame_done = 0, so = 0 (follows from data = 0), po = 0.
- Enable low (en=0): data and counter hold; frame_done = 0 next cycle.
- HOLD (00): data and counter hold; frame_done = 0.
- SHIFT (01), dir=0: data <= {si, data[WIDTH-1:1]}.
- SHIFT (01), dir=1: data <= {data[WIDTH-2:0], si}.
- SHIFT counter rule:
  - Counter increments on each shift.
  - If the counter == WIDTH-1 at the shifting edge, the counter wraps to 0 and frame_done is 1 for exactly the following cycle.
  - During that cycle po holds the complete word.
- LOAD (10): data <= pi; counter <= 0; frame_done = 0.
- ROTATE (11):
  - dir=0: data <= {data[0], data[WIDTH-1:1]}.
  - dir=1: data <= {data[WIDTH-2:0], data[WIDTH-1]}.
  - Counter unchanged; frame_done = 0.
- so is combinational from the register and dir: dir=0 gives data[0], dir=1 gives data[WIDTH-1], i.e. the bit leaving on the next shift.
- po = data register, registered output; zero latency after the edge.
- frame_done is registered: asserted in the cycle after the completing edge and deasserted one cycle later, unless that next edge also completes a frame. That can only happen for back-to-back frames when WIDTH would be 1, which is illegal.
- Mode changes mid-frame:
  - Switching SHIFT→HOLD/ROTATE→SHIFT keeps the partial count.
  - LOAD discards it.
  - Changing dir mid-frame is legal; the count continues.
- Reset mid-frame: partial count is discarded; a full WIDTH shifts are needed for the next frame_done.
- mode, dir, si and pi are sampled only at rising edges; there are no asynchronous paths except so.

Decomposition:
- Package shift_pkg holds localparams MODE_HOLD=2'b00, MODE_SHIFT=2'b01, MODE_LOAD=2'b10, MODE_ROTATE=2'b11, and DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
- One natural sub-module: frame_counter (parameter WIDTH).
  - Inputs: clk, rst, inc, clr.
  - Output: frame_done.
  - Holds the modulo-WIDTH counter and the registered strobe.
- The top level holds the data register, next-state mux and so mux.

Test Plan:
- Reset: rst=1 for 2 edges with si=1, mode=SHIFT, en=1 -> po=4'b0000, so=0, frame_done=0 throughout.
- SIPO right, WIDTH=4: after reset, mode=SHIFT, dir=0, si=1,0,1,0 on successive edges -> po=1000,0100,1010,0101; frame_done=1 only in the cycle after the 4th edge.
- SIPO left: dir=1, si=1,0,1,1 -> po=0001,0010,0101,1011; frame_done pulses once after the 4th edge.
- PISO: mode=LOAD, pi=4'b1100, then SHIFT dir=0 with si=0 for 4 edges -> so reads 0,0,1,1 (before each edge); po ends 0000; frame_done pulses after the 4th shift.
- Rotate and enable: load 1000, ROTATE dir=1 -> po=0001, then 0010. With en=0 for 3 edges -> po stays 0010, frame_done=0.
- Reset mid-frame: 2 SHIFT edges, rst=1 for one edge, then 3 SHIFT edges -> no frame_done. The 4th shift after reset -> frame_done=1 for one cycle.

Source files
------------

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared encodings for the universal shift register: the two-bit mode select
// and the one-bit shift/rotate direction.
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;  // toward bit 0
  localparam logic DIR_LEFT  = 1'b1;  // toward bit WIDTH-1

endpackage : shift_pkg

// File: rtl/frame_counter.sv
// ---------------------------------------------------------------------------
// frame_counter
// Counts serial shifts modulo WIDTH and raises a registered one-cycle strobe
// in the cycle after the shift that completes a WIDTH-bit frame.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset; clears count and strobe
//   inc        : one serial bit shifted in at this edge
//   clr        : discard the partial count (parallel load); wins over inc
//   frame_done : high for the one cycle following the completing shift
// ---------------------------------------------------------------------------
module frame_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic frame_done
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, regardless of statement order.
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign frame_done = done_q;

endmodule : frame_counter

// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
// WIDTH-bit register with runtime mode select: hold, serial shift, parallel
// load and rotate, in either direction. A frame strobe marks each group of
// WIDTH serial bits assembled since the last reset or load.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : clock enable; 0 holds all state
//   mode       : 00 hold, 01 shift, 10 load, 11 rotate
//   dir        : 0 right (toward bit 0), 1 left (toward bit WIDTH-1)
//   si         : serial data in
//   pi         : parallel data in
//   so         : serial data out, the bit that leaves on the next shift
//   po         : parallel data out (register contents)
//   frame_done : one-cycle strobe after the WIDTH-th serial shift
// ---------------------------------------------------------------------------
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             si,
  input  logic [WIDTH-1:0] pi,
  output logic             so,
  output logic [WIDTH-1:0] po,
  output logic             frame_done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             cnt_inc, cnt_clr;

  always_comb begin
    data_d  = data_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHIFT: begin
          data_d  = (dir == DIR_LEFT) ? {data_q[WIDTH-2:0], si}
                                      : {si, data_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_LOAD: begin
          data_d  = pi;
          cnt_clr = 1'b1;
        end
        MODE_ROTATE: begin
          data_d = (dir == DIR_LEFT) ? {data_q[WIDTH-2:0], data_q[WIDTH-1]}
                                     : {data_q[0], data_q[WIDTH-1:1]};
        end
        default: ;  // MODE_HOLD
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk        (clk),
    .rst        (rst),
    .inc        (cnt_inc),
    .clr        (cnt_clr),
    .frame_done (frame_done)
  );

  // Combinational from the register: shows the bit about to be shifted out.
  assign so = (dir == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];
  assign po = data_q;

endmodule : universal_shift_reg
